// File: rtl/main_memory_pkg.sv
// Shared sizing, INIT encodings and the power-up line image for main_memory.
package main_memory_pkg;

   localparam int unsigned WORD_SIZE      = 32;
   localparam int unsigned LINE_SIZE      = 128;
   localparam int unsigned OFFSET_SIZE    = $clog2(LINE_SIZE / 8);
   localparam int unsigned MEM_LINES      = 1024;
   localparam int unsigned MEM_LATENCY    = 4;
   localparam int unsigned WORDS_PER_LINE = LINE_SIZE / WORD_SIZE;
   localparam int unsigned WORD_BYTES     = WORD_SIZE / 8;

   typedef enum logic {
      INIT_ZERO = 1'b0,
      INIT_ADDR = 1'b1
   } init_e;

   typedef logic [WORD_SIZE-1:0] word_t;
   typedef logic [LINE_SIZE-1:0] line_t;

   // Power-up content of the line starting at byte address base.
   function automatic line_t init_line(input init_e mode, input word_t base);
      line_t l;
      l = '0;
      if (mode == INIT_ADDR) begin
         for (int unsigned w = 0; w < WORDS_PER_LINE; w++) begin
            l[w*WORD_SIZE +: WORD_SIZE] = base + word_t'(w * WORD_BYTES);
         end
      end
      return l;
   endfunction

endpackage

// File: rtl/main_memory_if.sv
// Cache <-> memory miss/eviction bus. The cache is the master, memory the slave.
interface main_memory_if;
   import main_memory_pkg::*;

   logic  mem_req;
   word_t mem_req_addr;
   logic  mem_res;
   word_t mem_res_addr;
   line_t mem_res_data;
   logic  mem_write;
   word_t mem_write_addr;
   line_t mem_write_data;

   modport master (
      output mem_req, mem_req_addr, mem_write, mem_write_addr, mem_write_data,
      input  mem_res, mem_res_addr, mem_res_data
   );

   modport slave (
      input  mem_req, mem_req_addr, mem_write, mem_write_addr, mem_write_data,
      output mem_res, mem_res_addr, mem_res_data
   );

endinterface

// File: rtl/main_memory_mem_req_pipe.sv
// Valid + line-address shift register for in-flight fill requests.
module mem_req_pipe #(
   parameter int unsigned STAGES = 3,
   parameter int unsigned ADDR_W = 28,
   parameter int unsigned IDX_W  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_addr,
   output logic              load,
   output logic [ADDR_W-1:0] load_addr,
   output logic [IDX_W-1:0]  load_idx
);

   localparam int unsigned FLAT_W = STAGES * ADDR_W;

   logic [STAGES-1:0]             valid_q;
   logic [STAGES-1:0][ADDR_W-1:0] addr_q;

   // Valid bits shift one stage per cycle; reset drops everything in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         valid_q <= STAGES'({valid_q, in_valid});
      end
   end

   // Addresses follow their valid bits; no reset needed.
   always_ff @(posedge clk) begin
      addr_q <= FLAT_W'({addr_q, in_addr});
   end

   assign load      = valid_q[STAGES-1];
   assign load_addr = addr_q[STAGES-1];
   assign load_idx  = addr_q[STAGES-1][IDX_W-1:0];

endmodule

// File: rtl/main_memory.sv
// Line-granular backing memory: fixed-latency pipelined fills, same-cycle write-backs.
module main_memory
   import main_memory_pkg::*;
#(
   parameter int unsigned MEM_LINES   = main_memory_pkg::MEM_LINES,
   parameter int unsigned MEM_LATENCY = main_memory_pkg::MEM_LATENCY,
   parameter init_e       INIT        = INIT_ZERO
) (
   input  logic         clk,
   input  logic         rst,
   main_memory_if.slave bus,
   output logic [31:0]  stat_reads,
   output logic [31:0]  stat_writes
);

   localparam int unsigned IDX_W   = $clog2(MEM_LINES);
   localparam int unsigned LADDR_W = WORD_SIZE - OFFSET_SIZE;

   if (MEM_LATENCY < 2) begin : g_bad_latency
      $error("main_memory: MEM_LATENCY must be >= 2");
   end
   if (MEM_LINES == 0 || (MEM_LINES & (MEM_LINES - 1)) != 0) begin : g_bad_lines
      $error("main_memory: MEM_LINES must be a power of 2");
   end

   line_t               mem [MEM_LINES];
   // Lines never written read back their INIT image, so the array needs no preload.
   logic [MEM_LINES-1:0] written = '0;

   logic               load;
   logic [LADDR_W-1:0] load_laddr;
   logic [IDX_W-1:0]   load_idx;
   logic [IDX_W-1:0]   write_idx;
   line_t              stored_line;
   line_t              load_line;
   logic               unused_bits;

   assign write_idx   = bus.mem_write_addr[OFFSET_SIZE +: IDX_W];
   assign unused_bits = ^{bus.mem_req_addr[OFFSET_SIZE-1:0], bus.mem_write_addr};

   mem_req_pipe #(
      .STAGES (MEM_LATENCY - 1),
      .ADDR_W (LADDR_W),
      .IDX_W  (IDX_W)
   ) u_req_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (bus.mem_req),
      .in_addr   (bus.mem_req_addr[WORD_SIZE-1:OFFSET_SIZE]),
      .load      (load),
      .load_addr (load_laddr),
      .load_idx  (load_idx)
   );

   // Line read for the response being loaded, with same-edge write forwarding.
   always_comb begin
      stored_line = init_line(INIT, word_t'({load_idx, {OFFSET_SIZE{1'b0}}}));
      if (written[load_idx]) begin
         stored_line = mem[load_idx];
      end
      load_line = stored_line;
      if (bus.mem_write && (write_idx == load_idx)) begin
         load_line = bus.mem_write_data;
      end
   end

   // Write-backs commit immediately and survive reset.
   always_ff @(posedge clk) begin
      if (bus.mem_write) begin
         mem[write_idx]     <= bus.mem_write_data;
         written[write_idx] <= 1'b1;
      end
   end

   // Response registers form the final pipeline stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.mem_res      <= 1'b0;
         bus.mem_res_addr <= '0;
         bus.mem_res_data <= '0;
      end else begin
         bus.mem_res <= load;
         if (load) begin
            bus.mem_res_addr <= {load_laddr, {OFFSET_SIZE{1'b0}}};
            bus.mem_res_data <= load_line;
         end
      end
   end

   // Request and write-back counters, wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_reads  <= '0;
         stat_writes <= '0;
      end else begin
         if (bus.mem_req) begin
            stat_reads <= stat_reads + 32'd1;
         end
         if (bus.mem_write) begin
            stat_writes <= stat_writes + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_main_memory.sv
// Directed bench for main_memory (MEM_LATENCY=4, MEM_LINES=1024, INIT=address image).
module tb_main_memory;
   import main_memory_pkg::*;

   localparam logic [127:0] D3 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0011_2233;
   localparam logic [127:0] D4 = 128'h4444_0000_1111_2222_3333_5555_6666_7777;
   localparam logic [127:0] D5 = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
   localparam logic [127:0] D6 = 128'h6666_0001_0002_0003_0004_0005_0006_0007;
   localparam logic [127:0] D7 = 128'h7777_FFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999;
   localparam logic [127:0] D8 = 128'h8888_1234_5678_9ABC_DEF0_0FED_CBA9_8765;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] stat_reads;
   logic [31:0] stat_writes;
   int unsigned checks = 0;
   int unsigned passes = 0;
   int unsigned fails  = 0;

   logic [31:0]  t2_addr [3] = '{32'h00, 32'h10, 32'h20};
   logic [127:0] t2_data [3] = '{
      {32'h0C, 32'h08, 32'h04, 32'h00},
      {32'h1C, 32'h18, 32'h14, 32'h10},
      {32'h2C, 32'h28, 32'h24, 32'h20}
   };

   main_memory_if mem_bus ();

   main_memory #(
      .MEM_LINES   (1024),
      .MEM_LATENCY (4),
      .INIT        (INIT_ADDR)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (mem_bus),
      .stat_reads  (stat_reads),
      .stat_writes (stat_writes)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      mem_bus.mem_req        = 1'b0;
      mem_bus.mem_req_addr   = '0;
      mem_bus.mem_write      = 1'b0;
      mem_bus.mem_write_addr = '0;
      mem_bus.mem_write_data = '0;
   endtask

   // Request in the current cycle (cycle 1); response expected only in cycle 5.
   task automatic read_line(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_addr, input logic [127:0] exp_data);
      mem_bus.mem_req      = 1'b1;
      mem_bus.mem_req_addr = addr;
      tick();
      mem_bus.mem_req = 1'b0;
      for (int k = 2; k <= 6; k++) begin
         chk({tag, " res"}, mem_bus.mem_res, (k == 5));
         if (k == 5) begin
            chk({tag, " addr"}, mem_bus.mem_res_addr, exp_addr);
            chk({tag, " data"}, mem_bus.mem_res_data, exp_data);
         end
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      tick(); tick(); tick();
      chk("reset res",    mem_bus.mem_res,      1'b0);
      chk("reset addr",   mem_bus.mem_res_addr, 32'h0);
      chk("reset data",   mem_bus.mem_res_data, 128'h0);
      chk("reset reads",  stat_reads,           32'h0);
      chk("reset writes", stat_writes,          32'h0);
      rst = 1'b0;

      // single read of the INIT image
      read_line("t1", 32'h40, 32'h40, {32'h4C, 32'h48, 32'h44, 32'h40});

      // back-to-back requests give back-to-back in-order responses
      mem_bus.mem_req      = 1'b1;
      mem_bus.mem_req_addr = 32'h00;
      tick();
      mem_bus.mem_req_addr = 32'h10;
      tick();
      mem_bus.mem_req_addr = 32'h20;
      tick();
      mem_bus.mem_req = 1'b0;
      for (int k = 4; k <= 8; k++) begin
         chk("t2 res", mem_bus.mem_res, (k >= 5 && k <= 7));
         if (k >= 5 && k <= 7) begin
            chk("t2 addr", mem_bus.mem_res_addr, t2_addr[k-5]);
            chk("t2 data", mem_bus.mem_res_data, t2_data[k-5]);
         end
         tick();
      end

      // write then read with nonzero offset bits
      mem_bus.mem_write      = 1'b1;
      mem_bus.mem_write_addr = 32'h100;
      mem_bus.mem_write_data = D3;
      tick();
      idle();
      read_line("t3", 32'h10C, 32'h100, D3);

      // same-edge forwarding: write in cycle 4 lands in cycle-5 response
      mem_bus.mem_req      = 1'b1;
      mem_bus.mem_req_addr = 32'h200;
      tick();
      mem_bus.mem_req = 1'b0;
      tick(); tick();
      mem_bus.mem_write      = 1'b1;
      mem_bus.mem_write_addr = 32'h200;
      mem_bus.mem_write_data = D4;
      tick();
      idle();
      chk("t4 res",  mem_bus.mem_res,      1'b1);
      chk("t4 addr", mem_bus.mem_res_addr, 32'h200);
      chk("t4 data", mem_bus.mem_res_data, D4);
      tick();
      chk("t4 pulse", mem_bus.mem_res, 1'b0);

      // eviction write while mem_res is high leaves the presented response alone
      mem_bus.mem_req      = 1'b1;
      mem_bus.mem_req_addr = 32'h210;
      tick();
      mem_bus.mem_req = 1'b0;
      tick(); tick(); tick();
      mem_bus.mem_write      = 1'b1;
      mem_bus.mem_write_addr = 32'h210;
      mem_bus.mem_write_data = D5;
      #1;
      chk("t4b res",  mem_bus.mem_res,      1'b1);
      chk("t4b data", mem_bus.mem_res_data, {32'h21C, 32'h218, 32'h214, 32'h210});
      tick();
      idle();

      // write to an in-flight line plus independent same-cycle req/write
      mem_bus.mem_req        = 1'b1;
      mem_bus.mem_req_addr   = 32'h220;
      mem_bus.mem_write      = 1'b1;
      mem_bus.mem_write_addr = 32'h300;
      mem_bus.mem_write_data = D7;
      tick();
      mem_bus.mem_req        = 1'b0;
      mem_bus.mem_write_addr = 32'h220;
      mem_bus.mem_write_data = D6;
      tick();
      idle();
      tick(); tick();
      chk("t4c res",  mem_bus.mem_res,      1'b1);
      chk("t4c addr", mem_bus.mem_res_addr, 32'h220);
      chk("t4c data", mem_bus.mem_res_data, D6);
      tick();

      // storage read-back
      read_line("rb200", 32'h200, 32'h200, D4);
      read_line("rb210", 32'h214, 32'h210, D5);
      read_line("rb300", 32'h300, 32'h300, D7);
      read_line("rb220", 32'h228, 32'h220, D6);
      chk("stat reads",  stat_reads,  32'd12);
      chk("stat writes", stat_writes, 32'd5);

      // reset with requests in flight: never answered, counters cleared
      mem_bus.mem_req      = 1'b1;
      mem_bus.mem_req_addr = 32'h40;
      tick();
      mem_bus.mem_req_addr = 32'h50;
      tick();
      mem_bus.mem_req = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5 reads",  stat_reads,  32'h0);
      chk("t5 writes", stat_writes, 32'h0);
      for (int k = 4; k <= 9; k++) begin
         chk("t5 res", mem_bus.mem_res, 1'b0);
         tick();
      end

      // address aliasing modulo MEM_LINES
      mem_bus.mem_write      = 1'b1;
      mem_bus.mem_write_addr = 32'h0000_0030;
      mem_bus.mem_write_data = D8;
      tick();
      idle();
      read_line("t6", 32'h0000_4030, 32'h0000_4030, D8);
      chk("t6 writes", stat_writes, 32'd1);
      chk("t6 reads",  stat_reads,  32'd1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
